// File: rtl/alu_pkg.sv
// Shared definitions for the execute/writeback stage: opcodes, FSM states and
// default datapath sizes.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_REG_BITS   = 2;
    localparam int unsigned DEFAULT_MUL_CYCLES = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } stateT;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle while run is high,
// done pulses on the last iteration with the final product presented combinationally.
module seq_multiplier #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] multiplicandIn,
    input  logic [WIDTH-1:0] multiplierIn,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CNT_BITS = $clog2(MUL_CYCLES);
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(MUL_CYCLES - 1);

    logic [WIDTH-1:0]    multiplicandQ;
    logic [WIDTH-1:0]    multiplierQ;
    logic [WIDTH-1:0]    accQ;
    logic [WIDTH-1:0]    accStep;
    logic [CNT_BITS-1:0] countQ;

    always_comb begin
        accStep = multiplierQ[0] ? accQ + multiplicandQ : accQ;
        done    = run && (countQ == LAST_COUNT);
        // Final product includes the partial product added on the last iteration.
        product = accStep;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            multiplicandQ <= '0;
            multiplierQ   <= '0;
            accQ          <= '0;
            countQ        <= '0;
        end else if (start) begin
            multiplicandQ <= multiplicandIn;
            multiplierQ   <= multiplierIn;
            accQ          <= '0;
            countQ        <= '0;
        end else if (run) begin
            multiplicandQ <= multiplicandQ << 1;
            multiplierQ   <= multiplierQ >> 1;
            accQ          <= accStep;
            countQ        <= countQ + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage behind the 4x32 register file: single-cycle ALU ops or an
// iterative multiply, each producing exactly one registered write-port pulse.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned REG_BITS   = DEFAULT_REG_BITS,
    parameter int unsigned MUL_CYCLES = DEFAULT_MUL_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inValid,
    output logic                inReady,
    input  logic [2:0]          op,
    input  logic [WIDTH-1:0]    operandA,
    input  logic [WIDTH-1:0]    operandB,
    input  logic [REG_BITS-1:0] destReg,
    output logic [WIDTH-1:0]    writeData,
    output logic [REG_BITS-1:0] writeReg,
    output logic                regWrite,
    output logic                busy
);

    stateT               stateQ, stateD;
    logic [REG_BITS-1:0] destQ, destD;
    logic [WIDTH-1:0]    writeDataD;
    logic [REG_BITS-1:0] writeRegD;
    logic                regWriteD;
    logic [WIDTH-1:0]    aluResult;
    logic                accept;
    logic                mulStart;
    logic                mulRun;
    logic                mulDone;
    logic [WIDTH-1:0]    mulProduct;

    assign inReady = (stateQ == ST_IDLE);
    assign busy    = (stateQ != ST_IDLE);
    assign accept  = inValid && inReady;
    assign mulRun  = (stateQ == ST_MUL);

    always_comb begin
        aluResult = '0;
        case (op)
            OP_ADD:  aluResult = operandA + operandB;
            OP_SUB:  aluResult = operandA - operandB;
            OP_AND:  aluResult = operandA & operandB;
            OP_OR:   aluResult = operandA | operandB;
            OP_SLT:  aluResult = WIDTH'($signed(operandA) < $signed(operandB));
            OP_SLL:  aluResult = operandA << operandB[4:0];
            default: aluResult = '0;
        endcase
    end

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock          (clock),
        .reset          (reset),
        .start          (mulStart),
        .run            (mulRun),
        .multiplicandIn (operandA),
        .multiplierIn   (operandB),
        .done           (mulDone),
        .product        (mulProduct)
    );

    always_comb begin
        stateD     = stateQ;
        destD      = destQ;
        writeDataD = writeData;
        writeRegD  = writeReg;
        regWriteD  = 1'b0;
        mulStart   = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (accept) begin
                    destD = destReg;
                    if (op == OP_MUL) begin
                        mulStart = 1'b1;
                        stateD   = ST_MUL;
                    end else if (op != OP_NOP) begin
                        writeDataD = aluResult;
                        writeRegD  = destReg;
                        regWriteD  = 1'b1;
                        stateD     = ST_WB;
                    end
                end
            end
            ST_MUL: begin
                if (mulDone) begin
                    writeDataD = mulProduct;
                    writeRegD  = destQ;
                    regWriteD  = 1'b1;
                    stateD     = ST_WB;
                end
            end
            ST_WB:   stateD = ST_IDLE;
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ    <= ST_IDLE;
            destQ     <= '0;
            writeData <= '0;
            writeReg  <= '0;
            regWrite  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            destQ     <= destD;
            writeData <= writeDataD;
            writeReg  <= writeRegD;
            regWrite  <= regWriteD;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: transaction-level model checked every cycle, plus
// directed vectors with literal expected results and a small register file.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic [2:0]  op = OP_NOP;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic [1:0]  destReg = '0;
    logic        inReady;
    logic [31:0] writeData;
    logic [1:0]  writeReg;
    logic        regWrite;
    logic        busy;

    alu_exec_stage #(
        .WIDTH      (32),
        .REG_BITS   (2),
        .MUL_CYCLES (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .destReg   (destReg),
        .writeData (writeData),
        .writeReg  (writeReg),
        .regWrite  (regWrite),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a << b[4:0];
            OP_MUL:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Transaction model: which edge accepts, when the write appears, when ready returns.
    typedef struct {
        int          at;
        logic [1:0]  r;
        logic [31:0] d;
    } wrT;

    wrT          expQ[$];
    int          cyc = 0;
    int          nextAccept = 0;
    logic [31:0] expData = '0;
    logic [1:0]  expReg = '0;
    logic        expRW;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!reset) begin
            expQ.delete();
            nextAccept = cyc + 1;
            expData = '0;
            expReg = '0;
        end else if (inValid && cyc >= nextAccept) begin
            if (op == OP_NOP) begin
                nextAccept = cyc + 1;
            end else if (op == OP_MUL) begin
                expQ.push_back('{cyc + 32, destReg, refResult(op, operandA, operandB)});
                nextAccept = cyc + 34;
            end else begin
                expQ.push_back('{cyc, destReg, refResult(op, operandA, operandB)});
                nextAccept = cyc + 2;
            end
        end
    end

    int          obsCount = 0;
    logic [31:0] obsData = '0;
    logic [1:0]  obsReg = '0;
    int          obsCyc = 0;

    always @(negedge clock) begin
        if (cyc >= 1) begin
            expRW = 1'b0;
            if (expQ.size() > 0 && expQ[0].at == cyc) begin
                expRW = 1'b1;
                expData = expQ[0].d;
                expReg = expQ[0].r;
                void'(expQ.pop_front());
            end
            check("model_regWrite", 32'(regWrite), 32'(expRW));
            check("model_writeData", writeData, expData);
            check("model_writeReg", 32'(writeReg), 32'(expReg));
            check("model_inReady", 32'(inReady), 32'(cyc + 1 >= nextAccept));
            check("model_busy", 32'(busy), 32'(cyc + 1 < nextAccept));
            if (regWrite === 1'b1) begin
                obsCount++;
                obsData = writeData;
                obsReg = writeReg;
                obsCyc = cyc;
            end
        end
    end

    logic [31:0] rf [4];

    always @(posedge clock) begin
        if (regWrite === 1'b1) rf[writeReg] <= writeData;
    end

    // Drives one instruction (called at a negedge); returns at the negedge after accept.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] d, output int acceptCyc);
        bit ok;
        ok = 1'b0;
        op = o;
        operandA = a;
        operandB = b;
        destReg = d;
        inValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (inReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) timeoutFail("accept");
        @(negedge clock);
        acceptCyc = cyc;
        inValid = 1'b0;
    endtask

    task automatic waitIdle(output int lowCycles);
        lowCycles = 0;
        while (inReady !== 1'b1 && lowCycles < 100) begin
            lowCycles++;
            @(negedge clock);
        end
        if (lowCycles >= 100) timeoutFail("wait_idle");
    endtask

    int acc;
    int acc2;
    int low;
    int countBefore;

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_inReady", 32'(inReady), 32'd1);

        issue(OP_ADD, 32'd15, 32'd27, 2'd3, acc);
        check("add_regWrite", 32'(regWrite), 32'd1);
        check("add_writeReg", 32'(writeReg), 32'd3);
        check("add_data", writeData, 32'd42);
        @(negedge clock);
        check("add_one_pulse", 32'(regWrite), 32'd0);

        issue(OP_SUB, 32'd5, 32'd7, 2'd1, acc);
        waitIdle(low);
        check("sub_data", obsData, 32'hFFFF_FFFE);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 2'd2, acc);
        waitIdle(low);
        check("slt_data", obsData, 32'd1);

        issue(OP_SLL, 32'd1, 32'h25, 2'd0, acc);
        waitIdle(low);
        check("sll_data", obsData, 32'd32);

        issue(OP_MUL, 32'd1234, 32'd5678, 2'd2, acc);
        waitIdle(low);
        check("mul_ready_low", low, 32'd33);
        check("mul_latency", obsCyc - acc, 32'd32);
        check("mul_data", obsData, 32'd7006652);
        check("mul_reg", 32'(obsReg), 32'd2);

        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 2'd1, acc);
        waitIdle(low);
        check("mul_wrap", obsData, 32'hFFFF_FFFE);

        countBefore = obsCount;
        issue(OP_ADD, 32'd100, 32'd23, 2'd0, acc);
        issue(OP_OR, 32'hF0, 32'h0F, 2'd1, acc2);
        check("b2b_accept_gap", acc2 - acc, 32'd2);
        waitIdle(low);
        @(negedge clock);
        check("b2b_writes", obsCount - countBefore, 32'd2);
        check("b2b_or_data", obsData, 32'hFF);
        check("b2b_rf0", rf[0], 32'd123);

        countBefore = obsCount;
        issue(OP_MUL, 32'd1234, 32'd5678, 2'd3, acc);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_inReady", 32'(inReady), 32'd1);
        repeat (40) @(negedge clock);
        check("abort_no_write", obsCount - countBefore, 32'd0);

        countBefore = obsCount;
        issue(OP_NOP, 32'd9, 32'd9, 2'd1, acc);
        repeat (3) @(negedge clock);
        check("nop_no_write", obsCount - countBefore, 32'd0);

        issue(OP_ADD, 32'd15, 32'd0, 2'd3, acc);
        waitIdle(low);
        @(negedge clock);
        check("rf_reg3", rf[3], 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
